// File: rtl/phased_pwm_pkg.sv
// Shared types and width helpers for the phased PWM transmitter array.
package phased_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BURST = 2'd2
  } burst_state_e;

  function automatic int cnt_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  function automatic int duty_width(input int period);
    return $clog2(period + 1);
  endfunction

endpackage

// File: rtl/pwm_phase_channel.sv
// One transducer channel: phase-shifted local count, duty compare, registered output.
module pwm_phase_channel
  import phased_pwm_pkg::*;
#(
  parameter int PERIOD = 10,
  localparam int CNT_W = cnt_width(PERIOD),
  localparam int DUTY_W = duty_width(PERIOD)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic [CNT_W-1:0]  phase_i,
  input  logic [DUTY_W-1:0] duty_i,
  input  logic              en_i,
  output logic              sig_o
);

  localparam int EXT_W = ((CNT_W >= DUTY_W) ? CNT_W : DUTY_W) + 1;
  localparam logic [EXT_W-1:0] PERIOD_EXT = EXT_W'(PERIOD);

  logic [EXT_W-1:0] cnt_ext_s;
  logic [EXT_W-1:0] phase_ext_s;
  logic [EXT_W-1:0] duty_ext_s;
  logic [EXT_W-1:0] lc_s;
  logic             sig_d;
  logic             sig_q;

  // Wrap the shifted count back into [0, PERIOD) without a modulo operator
  always_comb begin
    cnt_ext_s   = EXT_W'(cnt_i);
    phase_ext_s = EXT_W'(phase_i);
    duty_ext_s  = EXT_W'(duty_i);
    if (cnt_ext_s >= phase_ext_s) begin
      lc_s = cnt_ext_s - phase_ext_s;
    end else begin
      lc_s = cnt_ext_s + PERIOD_EXT - phase_ext_s;
    end
    sig_d = en_i & (lc_s < duty_ext_s);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/phased_pwm_array.sv
// Phase-shifted multi-channel PWM with boundary-synchronous config update.
// Optional burst engine enabled by defining PWM_BURST_EN.
module phased_pwm_array
  import phased_pwm_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int PERIOD_IN_CLOCK_CYCLES = 2500,
  parameter int DEFAULT_DUTY = PERIOD_IN_CLOCK_CYCLES / 2,
  parameter int BURST_LEN_W = 8,
  localparam int CNT_W = cnt_width(PERIOD_IN_CLOCK_CYCLES),
  localparam int DUTY_W = duty_width(PERIOD_IN_CLOCK_CYCLES)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [NUM_CHANNELS-1:0][CNT_W-1:0]  phase_in,
  input  logic [DUTY_W-1:0]                   duty_in,
  input  logic                                cfg_valid_in,
  output logic                                cfg_ready_out,
  input  logic                                trigger_in,
  input  logic [BURST_LEN_W-1:0]              burst_len_in,
  output logic                                busy_out,
  output logic                                period_start_out,
  output logic [NUM_CHANNELS-1:0]             sig_out
);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD_IN_CLOCK_CYCLES - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD_IN_CLOCK_CYCLES);
  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(DEFAULT_DUTY);

  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              pstart_q, pstart_d;
  logic                              boundary_s;
  logic                              cfg_fire_s;
  logic                              en_s;
  logic [NUM_CHANNELS-1:0][CNT_W-1:0] shadow_phase_q, shadow_phase_d;
  logic [NUM_CHANNELS-1:0][CNT_W-1:0] active_phase_q, active_phase_d;
  logic [DUTY_W-1:0]                 shadow_duty_q, shadow_duty_d;
  logic [DUTY_W-1:0]                 active_duty_q, active_duty_d;
  logic                              pending_q, pending_d;
  logic                              ready_q, ready_d;
  logic                              busy_q, busy_d;

  always_comb begin
    boundary_s = (cnt_q == CNT_LAST);
    if (boundary_s) begin
      cnt_d = CNT_W'(0);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    pstart_d = (cnt_q == CNT_W'(0));
  end

  // Capture into the shadow (saturated); promote to active only at a period boundary
  always_comb begin
    cfg_fire_s     = cfg_valid_in & ready_q;
    shadow_phase_d = shadow_phase_q;
    shadow_duty_d  = shadow_duty_q;
    active_phase_d = active_phase_q;
    active_duty_d  = active_duty_q;
    pending_d      = pending_q;
    if (cfg_fire_s) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (phase_in[i] > CNT_LAST) begin
          shadow_phase_d[i] = CNT_LAST;
        end else begin
          shadow_phase_d[i] = phase_in[i];
        end
      end
      if (duty_in > DUTY_MAX) begin
        shadow_duty_d = DUTY_MAX;
      end else begin
        shadow_duty_d = duty_in;
      end
      pending_d = 1'b1;
    end else if (boundary_s && pending_q) begin
      active_phase_d = shadow_phase_q;
      active_duty_d  = shadow_duty_q;
      pending_d      = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    ready_d = ~pending_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q          <= CNT_W'(0);
      pstart_q       <= 1'b0;
      shadow_phase_q <= '0;
      shadow_duty_q  <= DUTY_RST;
      active_phase_q <= '0;
      active_duty_q  <= DUTY_RST;
      pending_q      <= 1'b0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pstart_q       <= pstart_d;
      shadow_phase_q <= shadow_phase_d;
      shadow_duty_q  <= shadow_duty_d;
      active_phase_q <= active_phase_d;
      active_duty_q  <= active_duty_d;
      pending_q      <= pending_d;
      ready_q        <= ready_d;
      busy_q         <= busy_d;
    end
  end

`ifdef PWM_BURST_EN
  burst_state_e           state_q, state_d;
  logic [BURST_LEN_W-1:0] remaining_q, remaining_d;

  // Bursts arm on trigger and start on the next boundary, so they always begin at count 0
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_in && (burst_len_in != BURST_LEN_W'(0))) begin
          state_d     = ST_ARMED;
          remaining_d = burst_len_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (boundary_s) begin
          state_d = ST_BURST;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_BURST: begin
        if (boundary_s) begin
          if (remaining_q == BURST_LEN_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            remaining_d = remaining_q - BURST_LEN_W'(1);
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    en_s   = (state_q == ST_BURST);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      remaining_q <= BURST_LEN_W'(0);
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{trigger_in, burst_len_in};
  assign en_s     = 1'b1;
  assign busy_d   = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    pwm_phase_channel #(
      .PERIOD(PERIOD_IN_CLOCK_CYCLES)
    ) u_ch (
      .clk_i  (clk_in),
      .rst_i  (rst_in),
      .cnt_i  (cnt_q),
      .phase_i(active_phase_q[g]),
      .duty_i (active_duty_q),
      .en_i   (en_s),
      .sig_o  (sig_out[g])
    );
  end

  assign cfg_ready_out    = ready_q;
  assign busy_out         = busy_q;
  assign period_start_out = pstart_q;

endmodule

// File: tb/tb_phased_pwm_array.sv
// Directed bench for phased_pwm_array with PERIOD=10, 4 channels, default duty 5.
module tb_phased_pwm_array;

`ifdef PWM_BURST_EN
  localparam bit BURST_MODE = 1'b1;
`else
  localparam bit BURST_MODE = 1'b0;
`endif

  logic            clk;
  logic            rst_in;
  logic [3:0][3:0] phase_in;
  logic [3:0]      duty_in;
  logic            cfg_valid_in;
  logic            cfg_ready_out;
  logic            trigger_in;
  logic [7:0]      burst_len_in;
  logic            busy_out;
  logic            period_start_out;
  logic [3:0]      sig_out;

  int checks = 0;
  int errors = 0;

  phased_pwm_array #(
    .NUM_CHANNELS(4),
    .PERIOD_IN_CLOCK_CYCLES(10),
    .DEFAULT_DUTY(5),
    .BURST_LEN_W(8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .phase_in(phase_in),
    .duty_in(duty_in),
    .cfg_valid_in(cfg_valid_in),
    .cfg_ready_out(cfg_ready_out),
    .trigger_in(trigger_in),
    .burst_len_in(burst_len_in),
    .busy_out(busy_out),
    .period_start_out(period_start_out),
    .sig_out(sig_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0][9:0] gate(input logic [3:0][9:0] pat, input bit active);
    if (BURST_MODE && !active) return '0;
    return pat;
  endfunction

  function automatic logic [9:0] bexp(input logic [9:0] b);
    return BURST_MODE ? b : 10'h000;
  endfunction

  // Sample one full period (bit k = sample reflecting master count k), optionally driving cfg/trigger
  task automatic run_period(input string tag, input int cfg_at, input logic [3:0][3:0] ph,
                            input logic [3:0] du, input int trig_at, input logic [7:0] blen,
                            input logic [3:0][9:0] exp_sig, input logic [9:0] exp_rdy,
                            input logic [9:0] exp_busy);
    logic [3:0][9:0] got_sig;
    logic [9:0] got_rdy;
    logic [9:0] got_busy;
    int ps_cnt;
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!period_start_out && guard < 30);
    check({tag, "_sync"}, {31'd0, period_start_out}, 32'd1);
    ps_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      for (int c = 0; c < 4; c++) got_sig[c][k] = sig_out[c];
      got_rdy[k]  = cfg_ready_out;
      got_busy[k] = busy_out;
      ps_cnt += int'(period_start_out);
      if (k == cfg_at) begin
        phase_in = ph;
        duty_in = du;
        cfg_valid_in = 1'b1;
      end else begin
        cfg_valid_in = 1'b0;
      end
      if (k == trig_at) begin
        trigger_in = 1'b1;
        burst_len_in = blen;
      end else begin
        trigger_in = 1'b0;
      end
    end
    cfg_valid_in = 1'b0;
    trigger_in = 1'b0;
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_sig%0d", tag, c), {22'd0, got_sig[c]}, {22'd0, exp_sig[c]});
    check({tag, "_ready"}, {22'd0, got_rdy}, {22'd0, exp_rdy});
    check({tag, "_busy"}, {22'd0, got_busy}, {22'd0, exp_busy});
    check({tag, "_pstart_cnt"}, ps_cnt, 32'd1);
  endtask

  logic [3:0][9:0] p_all5, p_d5, p_d2, p_low, p_high, p_ph15;
  logic [3:0][3:0] ph_a, ph_b, ph_c, ph_one;

  initial begin
    p_all5 = {10'h01F, 10'h01F, 10'h01F, 10'h01F};
    p_d5   = {10'h20F, 10'h383, 10'h0F8, 10'h01F};
    p_d2   = {10'h201, 10'h180, 10'h018, 10'h003};
    p_low  = '0;
    p_high = {10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
    p_ph15 = {10'h01F, 10'h01F, 10'h01F, 10'h20F};
    ph_a   = {4'd9, 4'd7, 4'd3, 4'd0};
    ph_b   = {4'd9, 4'd7, 4'd3, 4'd15};
    ph_c   = {4'd0, 4'd0, 4'd0, 4'd15};
    ph_one = {4'd1, 4'd1, 4'd1, 4'd1};

    rst_in = 1'b1;
    phase_in = '0;
    duty_in = 4'd0;
    cfg_valid_in = 1'b0;
    trigger_in = 1'b0;
    burst_len_in = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_sig", {28'd0, sig_out}, 32'd0);
    check("rst_pstart", {31'd0, period_start_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready_out}, 32'd1);
    rst_in = 1'b0;

    run_period("p1_default", -1, ph_a, 4'd5, -1, 8'd0, gate(p_all5, 1'b0), 10'h3FF, 10'h000);
    run_period("p2_cfg_ph", 0, ph_a, 4'd5, -1, 8'd0, gate(p_all5, 1'b0), 10'h201, 10'h000);
    run_period("p3_cfg_mid", 3, ph_a, 4'd2, -1, 8'd0, gate(p_d5, 1'b0), 10'h20F, 10'h000);
    run_period("p4_duty0", 0, ph_a, 4'd0, -1, 8'd0, gate(p_d2, 1'b0), 10'h201, 10'h000);
    run_period("p5_duty12", 0, ph_b, 4'd12, -1, 8'd0, gate(p_low, 1'b0), 10'h201, 10'h000);
    run_period("p6_ph15", 0, ph_c, 4'd5, -1, 8'd0, gate(p_high, 1'b0), 10'h201, 10'h000);
    run_period("p7_sat", -1, ph_c, 4'd5, -1, 8'd0, gate(p_ph15, 1'b0), 10'h3FF, 10'h000);

    run_period("b0_trig", -1, ph_c, 4'd5, 5, 8'd3, gate(p_ph15, 1'b0), 10'h3FF, bexp(10'h3C0));
    run_period("b1", -1, ph_c, 4'd5, 2, 8'd5, gate(p_ph15, 1'b1), 10'h3FF, bexp(10'h3FF));
    run_period("b2", -1, ph_c, 4'd5, -1, 8'd0, gate(p_ph15, 1'b1), 10'h3FF, bexp(10'h3FF));
    run_period("b3", -1, ph_c, 4'd5, -1, 8'd0, gate(p_ph15, 1'b1), 10'h3FF, bexp(10'h1FF));
    run_period("b4_idle", -1, ph_c, 4'd5, -1, 8'd0, gate(p_ph15, 1'b0), 10'h3FF, 10'h000);

    run_period("r0_trig", -1, ph_c, 4'd5, 5, 8'd3, gate(p_ph15, 1'b0), 10'h3FF, bexp(10'h3C0));
    @(negedge clk);
    check("r_burst_start", {31'd0, period_start_out}, 32'd1);
    phase_in = ph_one;
    duty_in = 4'd1;
    cfg_valid_in = 1'b1;
    @(negedge clk);
    cfg_valid_in = 1'b0;
    check("r_pending_ready", {31'd0, cfg_ready_out}, 32'd0);
    check("r_burst_busy", {31'd0, busy_out}, {31'd0, BURST_MODE});
    rst_in = 1'b1;
    @(negedge clk);
    check("r_mid_sig", {28'd0, sig_out}, 32'd0);
    check("r_mid_pstart", {31'd0, period_start_out}, 32'd0);
    check("r_mid_busy", {31'd0, busy_out}, 32'd0);
    check("r_mid_ready", {31'd0, cfg_ready_out}, 32'd1);
    rst_in = 1'b0;
    run_period("r1_default", -1, ph_c, 4'd5, -1, 8'd0, gate(p_all5, 1'b0), 10'h3FF, 10'h000);
    run_period("r2_noshadow", -1, ph_c, 4'd5, -1, 8'd0, gate(p_all5, 1'b0), 10'h3FF, 10'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
